// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int DW_DEFAULT = 8;
    localparam int CNT_W      = $clog2(DW_DEFAULT + 1);
    localparam logic LINE_IDLE = 1'b1;

    // Bit-counter width for an arbitrary data width.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/serial_frame_rx_shifter.sv
// Enable-gated LSB-first deserializer with a running parity XOR.
module serial_frame_rx_shifter #(
    parameter int DW = 8
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_async_la_i,
    input  logic          clear,
    input  logic          shift,
    input  logic          fold,
    input  logic          bit_in,
    output logic [DW-1:0] data,
    output logic          parity
);

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (clear) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (shift) begin
            data   <= {bit_in, data[DW-1:1]};
            parity <= parity ^ bit_in;
        end else if (fold) begin
            parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start detect, LSB-first data, optional parity, stop,
// and a one-deep valid/ready output register with error pulses.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DW         = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_async_la_i,
    input  logic          D_i,
    input  logic          Enable_i,
    input  logic          Ready_i,
    output logic [DW-1:0] Data_o,
    output logic          Valid_o,
    output logic          Busy_o,
    output logic          Parity_err_o,
    output logic          Frame_err_o,
    output logic          Overrun_o
);

    localparam int CW = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [DW-1:0] shift_data;
    logic          shift_parity;
    logic          start;
    logic          shift;
    logic          fold;
    logic          stop_eval;
    logic          parity_bad;
    logic          good;
    logic          load;

    assign start      = Enable_i && (state == IDLE) && (D_i != LINE_IDLE);
    assign shift      = Enable_i && (state == DATA);
    assign fold       = Enable_i && (state == PARITY);
    assign stop_eval  = Enable_i && (state == STOP);
    // The running XOR already includes the parity bit, so a good frame leaves PARITY_ODD.
    assign parity_bad = (PARITY_EN != 1'b0) && (shift_parity != PARITY_ODD);
    assign good       = stop_eval && (D_i == LINE_IDLE) && !parity_bad;
    assign load       = good && (!Valid_o || Ready_i);

    always_comb begin
        state_next = state;
        if (Enable_i) begin
            case (state)
                IDLE: begin
                    if (D_i != LINE_IDLE) state_next = DATA;
                end
                DATA: begin
                    if (cnt == LAST) begin
                        if (PARITY_EN != 1'b0) state_next = PARITY;
                        else                   state_next = STOP;
                    end
                end
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state  <= IDLE;
            cnt    <= '0;
            Busy_o <= 1'b0;
        end else begin
            state  <= state_next;
            Busy_o <= (state_next != IDLE);
            if (start)      cnt <= '0;
            else if (shift) cnt <= cnt + 1'b1;
        end
    end

    serial_frame_rx_shifter #(.DW(DW)) u_shifter (
        .clk_50MHz_i    (clk_50MHz_i),
        .rst_async_la_i (rst_async_la_i),
        .clear          (start),
        .shift          (shift),
        .fold           (fold),
        .bit_in         (D_i),
        .data           (shift_data),
        .parity         (shift_parity)
    );

    // Output register: a load wins over a same-cycle transfer; a blocked good word is dropped.
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            Data_o       <= '0;
            Valid_o      <= 1'b0;
            Parity_err_o <= 1'b0;
            Frame_err_o  <= 1'b0;
            Overrun_o    <= 1'b0;
        end else begin
            Frame_err_o  <= stop_eval && (D_i != LINE_IDLE);
            Parity_err_o <= stop_eval && (D_i == LINE_IDLE) && parity_bad;
            Overrun_o    <= good && Valid_o && !Ready_i;
            if (load) begin
                Data_o  <= shift_data;
                Valid_o <= 1'b1;
            end else if (Valid_o && Ready_i) begin
                Valid_o <= 1'b0;
            end
        end
    end

endmodule
